// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one data RAM between two requesters, with registered RAM drive
// and tagged read-data return. Optional owner lock is compiled in with RAM_ARB_LOCK_EN.
module ram_port_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
`ifdef RAM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wen,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_out
);

    logic          r_ptr;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] r_waddr;
    logic          r_wen;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [RD_LAT:0] r_tag_vld;
    logic [RD_LAT:0] r_tag_id;

    logic          w_hold0;
    logic          w_hold1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_go;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // The owner is the last-granted requester; holding req&lock keeps it granted.
`ifdef RAM_ARB_LOCK_EN
    assign w_hold0 = ~r_ptr & req0 & lock0;
    assign w_hold1 =  r_ptr & req1 & lock1;
`else
    assign w_hold0 = 1'b0;
    assign w_hold1 = 1'b0;
`endif

    assign w_gnt0  = w_hold0 | (~w_hold1 & req0 & (~req1 | r_ptr));
    assign w_gnt1  = ~w_gnt0 & req1;
    assign w_go    = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_we    = w_sel ? we1    : we0;
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 1'b1;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            if (w_go) r_ptr <= w_sel;
            r_wen <= w_go & w_we;
            if (w_go & w_we) begin
                r_waddr <= w_addr;
                r_wdata <= w_wdata;
            end
            if (w_go & ~w_we) r_raddr <= w_addr;
            // Tag rides alongside the read; its last stage is the rvalid output stage.
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_go & ~w_we};
            r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_sel};
            if (r_tag_vld[RD_LAT-1]) r_rdata <= ram_out;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_tag_vld[RD_LAT] & ~r_tag_id[RD_LAT];
    assign rvalid1   = r_tag_vld[RD_LAT] &  r_tag_id[RD_LAT];
    assign rdata     = r_rdata;
    assign ram_raddr = r_raddr;
    assign ram_waddr = r_waddr;
    assign ram_wen   = r_wen;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM (address-registered,
// one-cycle read latency). Lock checks follow RAM_ARB_LOCK_EN.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, gnt0, rvalid0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic        req1, we1, gnt1, rvalid1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
`ifdef RAM_ARB_LOCK_EN
    logic        lock0, lock1;
`endif
    logic [31:0] rdata;
    logic [7:0]  ram_raddr, ram_waddr;
    logic        ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_out;

    logic [31:0] mem [256];
    int          tests;
    int          fails;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
`ifdef RAM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .rdata(rdata), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_out(ram_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM holds its address in ram_raddr, so data appears within the next cycle.
    assign ram_out = mem[ram_raddr];
    always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int gseq [8];
    int lseq [5];

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5]     = 32'h0000_1234;
        mem[8'h10] = 32'hA0A0_0010;
        mem[8'h20] = 32'hB0B0_0020;
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
`ifdef RAM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        #2;
        check("rst_raddr", {24'h0, ram_raddr}, 32'h0);
        check("rst_wen", {31'h0, ram_wen}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single read by requester 0.
        req0 = 1; we0 = 0; addr0 = 8'd5;
        #1;
        check("t1_gnt", {30'h0, gnt1, gnt0}, 32'h1);
        tick();
        req0 = 0;
        #1;
        check("t1_raddr", {24'h0, ram_raddr}, 32'd5);
        check("t1_rv_c1", {30'h0, rvalid1, rvalid0}, 32'h0);
        tick();
        check("t1_rv_c2", {30'h0, rvalid1, rvalid0}, 32'h1);
        check("t1_rdata", rdata, 32'h0000_1234);
        tick();
        check("t1_rv_c3", {30'h0, rvalid1, rvalid0}, 32'h0);

        // Contention: pointer is 0 after the last grant, so requester 1 leads.
        gseq = '{1, 0, 1, 0, 1, 0, -1, -1};
        addr0 = 8'h10; addr1 = 8'h20; we0 = 0; we1 = 0;
        for (int k = 0; k < 8; k++) begin
            req0 = (k < 6);
            req1 = (k < 6);
            #1;
            check($sformatf("t2_gnt%0d", k), {30'h0, gnt1, gnt0},
                  gseq[k] == 0 ? 32'h1 : gseq[k] == 1 ? 32'h2 : 32'h0);
            if (k >= 1 && gseq[k-1] >= 0)
                check($sformatf("t2_raddr%0d", k), {24'h0, ram_raddr},
                      gseq[k-1] == 0 ? 32'h10 : 32'h20);
            if (k >= 2) begin
                check($sformatf("t2_rv%0d", k), {30'h0, rvalid1, rvalid0},
                      gseq[k-2] == 0 ? 32'h1 : gseq[k-2] == 1 ? 32'h2 : 32'h0);
                if (gseq[k-2] >= 0)
                    check($sformatf("t2_rdata%0d", k), rdata,
                          gseq[k-2] == 0 ? 32'hA0A0_0010 : 32'hB0B0_0020);
            end
            tick();
        end

        // Write from requester 1 then read-back by requester 0.
        req1 = 1; we1 = 1; addr1 = 8'd200; wdata1 = 32'hDEAD_BEEF;
        #1;
        check("t3_gnt_w", {30'h0, gnt1, gnt0}, 32'h2);
        tick();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 8'd200;
        #1;
        check("t3_gnt_r", {30'h0, gnt1, gnt0}, 32'h1);
        check("t3_wen1", {31'h0, ram_wen}, 32'h1);
        check("t3_waddr", {24'h0, ram_waddr}, 32'd200);
        check("t3_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        req0 = 0;
        #1;
        check("t3_wen0", {31'h0, ram_wen}, 32'h0);
        check("t3_raddr", {24'h0, ram_raddr}, 32'd200);
        tick();
        check("t3_rv", {30'h0, rvalid1, rvalid0}, 32'h1);
        check("t3_rdata", rdata, 32'hDEAD_BEEF);
        tick();

        // Reset with a read in flight.
        req0 = 1; we0 = 0; addr0 = 8'd5;
        tick();
        req0 = 0;
        rst_n = 1'b0;
        #1;
        check("t4_rst_raddr", {24'h0, ram_raddr}, 32'h0);
        check("t4_rst_waddr", {24'h0, ram_waddr}, 32'h0);
        check("t4_rst_wdata", ram_wdata, 32'h0);
        check("t4_rst_rdata", rdata, 32'h0);
        check("t4_rst_rv", {30'h0, rvalid1, rvalid0}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_norv%0d", k), {30'h0, rvalid1, rvalid0}, 32'h0);
            tick();
        end
        req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h20;
        #1;
        check("t4_first_gnt", {30'h0, gnt1, gnt0}, 32'h1);
        tick();
        req0 = 0; req1 = 0;
        tick();
        tick();

        // Lock: pointer is 0 here, requester 1 requests throughout.
`ifdef RAM_ARB_LOCK_EN
        lseq = '{0, 0, 0, 0, 1};
`else
        lseq = '{1, 0, 1, 0, 1};
`endif
        for (int k = 0; k < 5; k++) begin
            req0 = 1; req1 = 1;
`ifdef RAM_ARB_LOCK_EN
            lock0 = (k < 4);
`endif
            #1;
            check($sformatf("t5_gnt%0d", k), {30'h0, gnt1, gnt0}, lseq[k] == 0 ? 32'h1 : 32'h2);
            tick();
        end
        req0 = 0; req1 = 0;
`ifdef RAM_ARB_LOCK_EN
        lock0 = 0;
`endif
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
